// File: rtl/cart_banker.sv
// Cartridge bank translator for a 7800-style cart bus. It has a one-entry hit buffer and a ROM fetch FSM.
// Optional 16KB RAM window at $4000-$7FFF is built only when CART_BANKER_RAM_EN is defined.
module cart_banker #(
  parameter int ROM_AW    = 18,
  parameter int BANK_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [15:0]          address_in,
  input  logic [7:0]           din,
  input  logic                 rw,
  input  logic                 cart_cs,
  input  logic [1:0]           cart_mode,
  input  logic [BANK_BITS-1:0] bank_mask,
  input  logic [15:0]          base_offset,
  input  logic                 ram_at_4k,
  output logic                 rom_req,
  output logic [ROM_AW-1:0]    rom_address,
  input  logic                 rom_ack,
  input  logic [7:0]           rom_din,
  output logic [7:0]           dout,
  output logic                 dout_valid,
  output logic                 busy
);
  localparam int BF = ROM_AW - 14;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIT   = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;

  logic [1:0]           state;
  logic [BANK_BITS-1:0] bank_reg;
  logic                 ent_vld, fill_ok;
  logic [ROM_AW-1:0]    ent_addr;
  logic [7:0]           ent_data;

  logic rd, wr, in_ram_win, in_rom, rom_rd, bank_wr;
  logic [BANK_BITS-1:0] bank_next, sg_bank;
  logic [3:0]           av_bank8;
  logic [1:0]           ab_bank;
  logic [15:0]          flat_a;
  logic [ROM_AW-1:0]    xlat;
  logic [7:0]           ram_rd_data;

  assign rd         = cart_cs && rw;
  assign wr         = cart_cs && !rw;
  assign in_ram_win = ram_at_4k && (address_in[15:14] == 2'b01);
  assign in_rom     = (address_in[15:14] != 2'b00) && !in_ram_win;
  assign rom_rd     = rd && in_rom;
  assign flat_a     = address_in - base_offset;

  always_comb begin
    bank_wr   = 1'b0;
    bank_next = din[BANK_BITS-1:0];
    if (wr) begin
      if ((cart_mode == 2'd1 || cart_mode == 2'd3) && address_in[15:14] == 2'b10)
        bank_wr = 1'b1;
      else if (cart_mode == 2'd2 && address_in[15:4] == 12'hFF8) begin
        bank_wr   = 1'b1;
        bank_next = BANK_BITS'(address_in[3:0]);
      end
    end
  end

  // Activision banks are 8K units. $A000 is the first byte of the switched
  // 16K bank, so the half-select within that bank is A[13] inverted.
  always_comb begin
    xlat     = '0;
    sg_bank  = '0;
    av_bank8 = '0;
    ab_bank  = '0;
    case (cart_mode)
      2'd0: xlat = ROM_AW'(flat_a);
      2'd1: begin
        case (address_in[15:14])
          2'b10:   sg_bank = bank_reg & bank_mask;
          2'b11:   sg_bank = bank_mask;
          default: sg_bank = bank_mask - 1'b1;
        endcase
        xlat = {BF'(sg_bank), address_in[13:0]};
      end
      2'd2: begin
        if (address_in >= 16'hE000)      av_bank8 = {3'b111, address_in[12]};
        else if (address_in >= 16'hA000) av_bank8 = {bank_reg[2:0], ~address_in[13]};
        else if (address_in[15:13] == 3'b010) av_bank8 = 4'd13;
        else if (address_in[15:13] == 3'b011) av_bank8 = 4'd12;
        else                                  av_bank8 = 4'd15;
        xlat = ROM_AW'({av_bank8, address_in[12:0]});
      end
      default: begin
        ab_bank = address_in[15] ? {1'b1, address_in[14]} : {1'b0, |bank_reg[1:0]};
        xlat    = ROM_AW'({ab_bank, address_in[13:0]});
      end
    endcase
  end

`ifdef CART_BANKER_RAM_EN
  logic [7:0] ram [0:16383];
  always_ff @(posedge clock)
    if (wr && in_ram_win) ram[address_in[13:0]] <= din;
  assign ram_rd_data = ram[address_in[13:0]];
`else
  logic unused_din;
  assign ram_rd_data = 8'hFF;
  assign unused_din  = ^din;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      bank_reg    <= '0;
      rom_req     <= 1'b0;
      rom_address <= '0;
      dout        <= 8'hFF;
      dout_valid  <= 1'b0;
      busy        <= 1'b0;
      ent_vld     <= 1'b0;
      ent_addr    <= '0;
      ent_data    <= 8'hFF;
      fill_ok     <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (bank_wr) begin
        bank_reg <= bank_next;
        ent_vld  <= 1'b0;
        fill_ok  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (rom_rd) begin
            if (ent_vld && ent_addr == xlat) begin
              dout       <= ent_data;
              dout_valid <= 1'b1;
              state      <= S_HIT;
            end else begin
              rom_req     <= 1'b1;
              busy        <= 1'b1;
              rom_address <= xlat;
              fill_ok     <= 1'b1;
              state       <= S_FETCH;
            end
          end else if (rd) begin
            dout       <= in_ram_win ? ram_rd_data : 8'hFF;
            dout_valid <= 1'b1;
          end
        end
        S_HIT: state <= S_IDLE;
        S_FETCH: begin
          // A bank write during the fetch leaves the fill data unusable for later hits.
          if (rom_ack) begin
            dout       <= rom_din;
            dout_valid <= 1'b1;
            rom_req    <= 1'b0;
            busy       <= 1'b0;
            ent_addr   <= rom_address;
            ent_data   <= rom_din;
            ent_vld    <= fill_ok && !bank_wr;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cart_banker.sv
// Directed bench for cart_banker: bank mapping per mode, hit buffer, fetch handshake, reset abort.
module tb_cart_banker;
  logic        clock, reset;
  logic [15:0] address_in, base_offset;
  logic [7:0]  din, rom_din, dout;
  logic        rw, cart_cs, ram_at_4k, rom_ack, rom_req, dout_valid, busy;
  logic [1:0]  cart_mode;
  logic [3:0]  bank_mask;
  logic [17:0] rom_address;
  int total = 0;
  int bad   = 0;

  cart_banker #(.ROM_AW(18), .BANK_BITS(4)) dut (
    .clock(clock), .reset(reset), .address_in(address_in), .din(din), .rw(rw),
    .cart_cs(cart_cs), .cart_mode(cart_mode), .bank_mask(bank_mask),
    .base_offset(base_offset), .ram_at_4k(ram_at_4k), .rom_req(rom_req),
    .rom_address(rom_address), .rom_ack(rom_ack), .rom_din(rom_din),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address_in = a; din = d; rw = 1'b0; cart_cs = 1'b1;
    cyc();
    cart_cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a);
    address_in = a; rw = 1'b1; cart_cs = 1'b1;
    cyc();
    cart_cs = 1'b0;
  endtask

  task automatic ack(input string tag, input logic [7:0] d);
    rom_din = d; rom_ack = 1'b1;
    cyc();
    rom_ack = 1'b0;
    chk({tag, "_vld"}, dout_valid, 1);
    chk({tag, "_dout"}, dout, d);
    chk({tag, "_reqdrop"}, rom_req, 0);
    chk({tag, "_busy"}, busy, 0);
    cyc();
    chk({tag, "_vldpulse"}, dout_valid, 0);
  endtask

  task automatic fetch(input string tag, input logic [15:0] a, input logic [17:0] ea, input logic [7:0] d);
    rd(a);
    chk({tag, "_req"}, rom_req, 1);
    chk({tag, "_addr"}, rom_address, ea);
    ack(tag, d);
  endtask

  task automatic hit(input string tag, input logic [15:0] a, input logic [7:0] d);
    rd(a);
    chk({tag, "_noreq"}, rom_req, 0);
    chk({tag, "_vld"}, dout_valid, 1);
    chk({tag, "_dout"}, dout, d);
    cyc();
  endtask

  initial begin
    reset = 1'b1; address_in = '0; din = '0; rw = 1'b1; cart_cs = 1'b0;
    cart_mode = 2'd1; bank_mask = 4'd7; base_offset = '0; ram_at_4k = 1'b0;
    rom_ack = 1'b0; rom_din = '0;
    #1;
    chk("rst_req", rom_req, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_vld", dout_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // SuperGame: bank 5, fetch, stall with an ignored read, then fill
    wr(16'h8000, 8'h05);
    rd(16'h8123);
    chk("sg_req", rom_req, 1);
    chk("sg_busy", busy, 1);
    chk("sg_addr", rom_address, 18'h14123);
    rd(16'hC000);
    chk("sg_hold_addr", rom_address, 18'h14123);
    chk("sg_hold_req", rom_req, 1);
    chk("sg_hold_vld", dout_valid, 0);
    ack("sg_fill", 8'h3C);
    hit("sg_hit", 16'h8123, 8'h3C);
    wr(16'h8000, 8'h02);
    fetch("sg_bank2", 16'h8123, 18'h08123, 8'h5A);
    fetch("sg_fixed", 16'hC010, 18'h1C010, 8'h11);
    fetch("sg_low", 16'h4020, 18'h18020, 8'h22);

    // bank write mid-fetch: address stays put, fill is not cached
    rd(16'h8200);
    chk("bwf_addr0", rom_address, 18'h08200);
    wr(16'h8000, 8'h03);
    chk("bwf_addr1", rom_address, 18'h08200);
    chk("bwf_req", rom_req, 1);
    ack("bwf_fill", 8'h77);
    bank_mask = 4'd2;
    fetch("bwf_miss", 16'h8200, 18'h08200, 8'h88);
    hit("bwf_hit", 16'h8200, 8'h88);
    bank_mask = 4'd7;

    // Activision
    cart_mode = 2'd2;
    wr(16'hFF83, 8'h00);
    fetch("av_sw", 16'hA010, 18'h0C010, 8'h31);
    fetch("av_e0", 16'hE000, 18'h1C000, 8'h32);
    fetch("av_f0", 16'hF000, 18'h1F000, 8'h33);
    fetch("av_50", 16'h5000, 18'h1B000, 8'h34);

    // Absolute
    cart_mode = 2'd3;
    wr(16'h8000, 8'h01);
    fetch("ab_lo", 16'h4010, 18'h04010, 8'h41);
    fetch("ab_c0", 16'hC010, 18'h0C010, 8'h42);
    fetch("ab_80", 16'h8010, 18'h08010, 8'h43);

    // flat
    cart_mode = 2'd0; base_offset = 16'h8000;
    fetch("flat", 16'hC001, 18'h04001, 8'h51);
    rd(16'h2000);
    chk("unmap_noreq", rom_req, 0);
    chk("unmap_vld", dout_valid, 1);
    chk("unmap_dout", dout, 8'hFF);
    cyc();

    // stray ack in IDLE
    rom_din = 8'h99; rom_ack = 1'b1;
    cyc();
    rom_ack = 1'b0;
    chk("stray_vld", dout_valid, 0);
    chk("stray_dout", dout, 8'hFF);

    // RAM window
    ram_at_4k = 1'b1;
    wr(16'h4005, 8'hA5);
    rd(16'h4005);
    chk("ram_noreq", rom_req, 0);
    chk("ram_vld", dout_valid, 1);
`ifdef CART_BANKER_RAM_EN
    chk("ram_dout", dout, 8'hA5);
`else
    chk("ram_dout", dout, 8'hFF);
`endif
    cyc();
    ram_at_4k = 1'b0;

    // reset during fetch
    base_offset = 16'h0000;
    rd(16'h9000);
    chk("rstf_req", rom_req, 1);
    chk("rstf_addr", rom_address, 18'h09000);
    #2 reset = 1'b1;
    #1;
    chk("rstf_drop", rom_req, 0);
    chk("rstf_busy", busy, 0);
    cyc();
    reset = 1'b0;
    rom_din = 8'h66; rom_ack = 1'b1;
    cyc();
    rom_ack = 1'b0;
    chk("rstf_lateack", dout_valid, 0);
    chk("rstf_req2", rom_req, 0);
    chk("rstf_dout", dout, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
